// File: rtl/aes_pkg.sv
// AES helpers shared by the AES-256 encipher core: S-box, xtime, key schedule step, FSM encoding.
`default_nettype none

package aes_pkg;

   localparam logic [3:0] NR = 4'd14;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } fsm_t;

   // Element 0 is the leftmost byte.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input logic [2:0] i);
      return 8'h01 << i;
   endfunction

   // One AES-256 schedule step: eight words in, next eight words out.
   function automatic logic [255:0] key_expand(input logic [255:0] w, input logic [2:0] rc);
      logic [31:0] t;
      logic [31:0] u;
      logic [31:0] n0, n1, n2, n3, n4, n5, n6, n7;
      t  = sub_word({w[23:0], w[31:24]}) ^ {rcon(rc), 24'h0};
      n0 = w[255:224] ^ t;
      n1 = w[223:192] ^ n0;
      n2 = w[191:160] ^ n1;
      n3 = w[159:128] ^ n2;
      u  = sub_word(n3);
      n4 = w[127:96] ^ u;
      n5 = w[95:64]  ^ n4;
      n6 = w[63:32]  ^ n5;
      n7 = w[31:0]   ^ n6;
      return {n0, n1, n2, n3, n4, n5, n6, n7};
   endfunction

endpackage

`default_nettype wire

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns (skipped when last), AddRoundKey.
`default_nettype none

module aes_enc_round
   import aes_pkg::*;
(
   input  logic [127:0] state_i,
   input  logic [127:0] rk_i,
   input  logic         last_i,
   output logic [127:0] state_o
);

   logic [7:0] sb [16];
   logic [7:0] sr [16];
   logic [7:0] mc [16];
   logic [7:0] a0, a1, a2, a3;

   always_comb begin
      state_o = '0;
      a0 = '0;
      a1 = '0;
      a2 = '0;
      a3 = '0;
      for (int i = 0; i < 16; i++) begin
         sb[i] = sbox(state_i[127-8*i -: 8]);
      end
      // Byte index is row + 4*column; row r rotates left by r columns.
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr[4*c+r] = sb[4*((c+r)&3)+r];
         end
      end
      for (int c = 0; c < 4; c++) begin
         a0 = sr[4*c];
         a1 = sr[4*c+1];
         a2 = sr[4*c+2];
         a3 = sr[4*c+3];
         mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      for (int i = 0; i < 16; i++) begin
         state_o[127-8*i -: 8] = (last_i ? sr[i] : mc[i]) ^ rk_i[127-8*i -: 8];
      end
   end

endmodule

`default_nettype wire

// File: rtl/aes256_encipher_iter.sv
// Iterative AES-256 encipher, valid/ready on both sides, on-the-fly key schedule.
// Define AES256_ENC_2RPC_EN for two rounds per clock (7-edge latency instead of 14).
`default_nettype none

module aes256_encipher_iter
   import aes_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     datain,
   input  logic [255:0]     key,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     dataout,
   output logic [TAG_W-1:0] tag_out,
   output logic             busy
);

   fsm_t             fsm_q, fsm_d;
   logic [3:0]       rnd_q, rnd_d;
   logic [127:0]     state_q, state_d;
   logic [255:0]     w_q, w_d;
   logic [127:0]     dout_q, dout_d;
   logic [TAG_W-1:0] tag_run_q, tag_run_d;
   logic [TAG_W-1:0] tag_out_q, tag_out_d;

   logic             accept;
   logic [2:0]       rc;
   logic [255:0]     wn;
   logic [127:0]     rnd_out;
   logic             last_step;
   logic             w_step;
   logic [3:0]       rnd_inc;

   assign in_ready  = (fsm_q == IDLE) | ((fsm_q == DONE) & out_ready);
   assign out_valid = (fsm_q == DONE);
   assign busy      = (fsm_q == RUN);
   assign dataout   = dout_q;
   assign tag_out   = tag_out_q;
   assign accept    = in_valid & in_ready;

`ifdef AES256_ENC_2RPC_EN
   logic [127:0] mid_state;

   // rnd_q is the odd round of the pair; the even round uses the fresh schedule step.
   assign rc        = rnd_q[3:1];
   assign wn        = key_expand(w_q, rc);
   assign last_step = (rnd_q == NR - 4'd1);
   assign w_step    = 1'b1;
   assign rnd_inc   = 4'd2;

   aes_enc_round u_round_a (
      .state_i (state_q),
      .rk_i    (w_q[127:0]),
      .last_i  (1'b0),
      .state_o (mid_state)
   );

   aes_enc_round u_round_b (
      .state_i (mid_state),
      .rk_i    (wn[255:128]),
      .last_i  (last_step),
      .state_o (rnd_out)
   );
`else
   logic [127:0] rk;

   // Odd rounds use the low half of the held words, even rounds the next schedule step.
   assign rc        = rnd_q[3:1] - 3'd1;
   assign wn        = key_expand(w_q, rc);
   assign rk        = rnd_q[0] ? w_q[127:0] : wn[255:128];
   assign last_step = (rnd_q == NR);
   assign w_step    = ~rnd_q[0];
   assign rnd_inc   = 4'd1;

   aes_enc_round u_round (
      .state_i (state_q),
      .rk_i    (rk),
      .last_i  (last_step),
      .state_o (rnd_out)
   );
`endif

   always_comb begin
      fsm_d     = fsm_q;
      rnd_d     = rnd_q;
      state_d   = state_q;
      w_d       = w_q;
      dout_d    = dout_q;
      tag_run_d = tag_run_q;
      tag_out_d = tag_out_q;
      case (fsm_q)
         RUN: begin
            state_d = rnd_out;
            if (w_step) begin
               w_d = wn;
            end
            if (last_step) begin
               fsm_d     = DONE;
               rnd_d     = 4'd0;
               dout_d    = rnd_out;
               tag_out_d = tag_run_q;
            end else begin
               rnd_d = rnd_q + rnd_inc;
            end
         end
         DONE: begin
            if (out_ready) begin
               fsm_d = IDLE;
            end
         end
         default: begin
            fsm_d = fsm_q;
         end
      endcase
      // Accept can only occur from IDLE or a completing DONE, so it overrides cleanly.
      if (accept) begin
         fsm_d     = RUN;
         rnd_d     = 4'd1;
         state_d   = datain ^ key[255:128];
         w_d       = key;
         tag_run_d = tag_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q     <= IDLE;
         rnd_q     <= 4'd0;
         state_q   <= '0;
         w_q       <= '0;
         dout_q    <= '0;
         tag_run_q <= '0;
         tag_out_q <= '0;
      end else begin
         fsm_q     <= fsm_d;
         rnd_q     <= rnd_d;
         state_q   <= state_d;
         w_q       <= w_d;
         dout_q    <= dout_d;
         tag_run_q <= tag_run_d;
         tag_out_q <= tag_out_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_aes256_encipher_iter.sv
// Scoreboard bench for aes256_encipher_iter using FIPS-197 / SP800-38A vectors.
`default_nettype none

module tb_aes256_encipher_iter;

   localparam int TAG_W = 4;
`ifdef AES256_ENC_2RPC_EN
   localparam int LAT = 7;
`else
   localparam int LAT = 14;
`endif

   localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [255:0] SP_KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [127:0]     datain;
   logic [255:0]     key;
   logic [TAG_W-1:0] tag_in;
   logic             out_valid;
   logic             out_ready;
   logic [127:0]     dataout;
   logic [TAG_W-1:0] tag_out;
   logic             busy;

   aes256_encipher_iter #(.TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .datain    (datain),
      .key       (key),
      .tag_in    (tag_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dataout   (dataout),
      .tag_out   (tag_out),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [127:0]     ct;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t exp_q[$];
   int   acc_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   last_acc = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: latency on each rising out_valid, data/tag on each output handshake.
   logic prev_ov = 1'b0;
   exp_t mon_e;
   int   mon_a;
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && !prev_ov) begin
            if (acc_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_out_valid: got out_valid=1 with no block pending, expected 0");
            end else begin
               mon_a = acc_q.pop_front();
               check("latency", 256'(cyc - mon_a), 256'(LAT));
            end
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("ciphertext", {128'h0, dataout}, {128'h0, mon_e.ct});
               check("tag_out", 256'(tag_out), 256'(mon_e.tag));
            end
         end
      end
      prev_ov = out_valid;
   end

   // Issue one block; called just after a posedge. gap_exp>0 checks spacing to previous accept.
   task automatic send(input logic [127:0] pt, input logic [255:0] k, input logic [TAG_W-1:0] tg,
                       input logic [127:0] ct, input bit track, input int gap_exp);
      int t;
      int acc;
      t        = 0;
      datain   = pt;
      key      = k;
      tag_in   = tg;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         check("accept_timeout", 256'(in_ready), 256'(1));
         in_valid = 1'b0;
         return;
      end
      acc = cyc + 1;
      if (track) begin
         exp_q.push_back('{ct: ct, tag: tg});
         acc_q.push_back(acc);
      end
      if (gap_exp > 0) check("accept_gap", 256'(acc - last_acc), 256'(gap_exp));
      last_acc = acc;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      datain   = 'x;
      key      = 'x;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || out_valid) && t < 400) begin
         @(negedge clk);
         t++;
      end
      check("drain_pending", 256'(exp_q.size()), 256'(0));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      datain    = '0;
      key       = '0;
      tag_in    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 256'(in_ready), 256'(1));
      check("rst_out_valid", 256'(out_valid), 256'(0));
      check("rst_busy", 256'(busy), 256'(0));
      check("rst_dataout", {128'h0, dataout}, 256'h0);
      check("rst_tag_out", 256'(tag_out), 256'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // FIPS-197 C.3
      send(C3_PT, C3_KEY, 4'd5, C3_CT, 1'b1, 0);
      @(negedge clk);
      check("busy_in_run", 256'(busy), 256'(1));
      check("in_ready_in_run", 256'(in_ready), 256'(0));
      drain();

      // All-zero key and plaintext
      send(128'h0, 256'h0, 4'd9, 128'hdc95c078a2408989ad48a21492842087, 1'b1, 0);
      drain();

      // SP800-38A ECB-AES256, back-to-back
      send(128'h6bc1bee22e409f96e93d7e117393172a, SP_KEY, 4'd0, 128'hf3eed1bdb5d2a03c064b5a7e3db181f8, 1'b1, 0);
      send(128'hae2d8a571e03ac9c9eb76fac45af8e51, SP_KEY, 4'd1, 128'h591ccb10d410ed26dc5ba74a31362870, 1'b1, LAT + 1);
      send(128'h30c81c46a35ce411e5fbc1191a0a52ef, SP_KEY, 4'd2, 128'hb6ed21b99ca6f4f9f153e7b1beafed1d, 1'b1, LAT + 1);
      send(128'hf69f2445df4f9b17ad2b417be66c3710, SP_KEY, 4'd3, 128'h23304b7a39f9f3ff067d8d8f9e24ecc7, 1'b1, LAT + 1);
      drain();

      // Backpressure: output held, a competing block must not be accepted
      out_ready = 1'b0;
      send(C3_PT, C3_KEY, 4'd7, C3_CT, 1'b1, 0);
      begin
         int t;
         t = 0;
         while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
         end
      end
      check("bp_out_valid_rise", 256'(out_valid), 256'(1));
      @(posedge clk);
      #1;
      datain   = 128'h0;
      key      = 256'h0;
      tag_in   = 4'd2;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("bp_dataout", {128'h0, dataout}, {128'h0, C3_CT});
         check("bp_tag_out", 256'(tag_out), 256'(7));
         check("bp_in_ready", 256'(in_ready), 256'(0));
         check("bp_out_valid", 256'(out_valid), 256'(1));
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();
      @(negedge clk);
      check("bp_no_accept_busy", 256'(busy), 256'(0));
      check("bp_out_valid_drop", 256'(out_valid), 256'(0));
      @(posedge clk);
      #1;

      // Reset during round 7
      send(C3_PT, C3_KEY, 4'd3, C3_CT, 1'b0, 0);
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_in_ready", 256'(in_ready), 256'(1));
      check("midrst_busy", 256'(busy), 256'(0));
      check("midrst_out_valid", 256'(out_valid), 256'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("post_rst_out_valid", 256'(out_valid), 256'(0));
      end
      @(posedge clk);
      #1;
      send(C3_PT, C3_KEY, 4'd12, C3_CT, 1'b1, 0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
